// File: rtl/wb_router.sv
// Routes ALU results to register A/B, discards them, or issues a memory write and waits for ack.
// Latency: register writes land at the transfer edge; memory writes hold until ack or TIMEOUT cycles.
// Backpressure: res_ready drops for the whole memory-write wait, so one write is in flight at a time.
module wb_router #(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [WIDTH-1:0]  res_data,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic [1:0]        dest,
    output logic [WIDTH-1:0]  reg_a,
    output logic [WIDTH-1:0]  reg_b,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ack,
    output logic              err,
    input  logic              err_clr,
    output logic [7:0]        wr_count
);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    localparam logic [1:0] DEST_A    = 2'b00;
    localparam logic [1:0] DEST_B    = 2'b01;
    localparam logic [1:0] DEST_MEM  = 2'b11;
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] tcnt;

    assign res_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            reg_a     <= '0;
            reg_b     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            wr_count  <= '0;
            tcnt      <= '0;
        end else begin
            // A timeout below overrides this clear on the same edge.
            if (err_clr)
                err <= 1'b0;
            case (state)
                IDLE: begin
                    if (res_valid) begin
                        case (dest)
                            DEST_A: reg_a <= res_data;
                            DEST_B: reg_b <= res_data;
                            DEST_MEM: begin
                                mem_addr  <= res_addr;
                                mem_wdata <= res_data;
                                mem_we    <= 1'b1;
                                tcnt      <= '0;
                                state     <= WAIT_ACK;
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT_ACK: begin
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        wr_count <= wr_count + 8'd1;
                        state    <= IDLE;
                    end else if (tcnt == TO_LAST) begin
                        mem_we <= 1'b0;
                        err    <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_router.sv
// Directed bench for wb_router with a cycle-level reference model and per-cycle comparison.
module tb_wb_router;

    localparam int WIDTH   = 8;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  res_data;
    logic [ADDR_W-1:0] res_addr;
    logic [1:0]        dest;
    logic [WIDTH-1:0]  reg_a, reg_b;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_ack;
    logic              err;
    logic              err_clr;
    logic [7:0]        wr_count;

    int checks   = 0;
    int failures = 0;

    wb_router #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_addr(res_addr), .dest(dest),
        .reg_a(reg_a), .reg_b(reg_b),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .err(err), .err_clr(err_clr), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Reference model: a write is "busy" for at most TIMEOUT cycles after acceptance.
    int m_a, m_b, m_addr, m_wdata, m_cnt, m_waited;
    bit m_busy, m_we, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_addr = 0; m_wdata = 0; m_cnt = 0;
            m_waited = 0; m_busy = 0; m_we = 0; m_err = 0;
        end else begin
            if (err_clr) m_err = 0;
            if (m_busy) begin
                m_waited = m_waited + 1;
                if (mem_ack) begin
                    m_busy = 0; m_we = 0; m_cnt = (m_cnt + 1) % 256;
                end else if (m_waited >= TIMEOUT) begin
                    m_busy = 0; m_we = 0; m_err = 1;
                end
            end else if (res_valid) begin
                if (dest == 2'd0) m_a = int'(res_data);
                else if (dest == 2'd1) m_b = int'(res_data);
                else if (dest == 2'd3) begin
                    m_addr = int'(res_addr); m_wdata = int'(res_data);
                    m_we = 1; m_busy = 1; m_waited = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("cyc_res_ready", 32'(res_ready), 32'(!m_busy));
            chk("cyc_reg_a",     32'(reg_a),     m_a);
            chk("cyc_reg_b",     32'(reg_b),     m_b);
            chk("cyc_mem_we",    32'(mem_we),    32'(m_we));
            chk("cyc_mem_addr",  32'(mem_addr),  m_addr);
            chk("cyc_mem_wdata", 32'(mem_wdata), m_wdata);
            chk("cyc_err",       32'(err),       32'(m_err));
            chk("cyc_wr_count",  32'(wr_count),  m_cnt);
        end
    end

    // Offer one result for a single cycle; returns at the negedge after the transfer edge.
    task automatic send(input logic [1:0] d, input logic [7:0] data, input logic [7:0] addr);
        @(negedge clk);
        res_valid = 1'b1; dest = d; res_data = data; res_addr = addr;
        @(negedge clk);
        res_valid = 1'b0; res_data = 8'h00; res_addr = 8'h00; dest = 2'b10;
    endtask

    task automatic ack_after(input int waits);
        repeat (waits) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    int hi;
    logic [7:0] cnt0;

    initial begin
        rst_n = 1'b0; res_valid = 1'b0; res_data = '0; res_addr = '0;
        dest = 2'b10; mem_ack = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(res_ready), 32'd1);
        chk("reset_regs",  {reg_a, reg_b, wr_count}, 32'd0);
        rst_n = 1'b1;

        // Back-to-back register writes
        @(negedge clk);
        res_valid = 1'b1; dest = 2'b00; res_data = 8'h5A;
        @(negedge clk);
        chk("rega_first", 32'(reg_a), 32'h5A);
        dest = 2'b01; res_data = 8'hC3;
        @(negedge clk);
        res_valid = 1'b0; dest = 2'b10;
        chk("regs_pair", {reg_a, reg_b}, 32'h5AC3);
        chk("regs_no_we", 32'(mem_we), 32'd0);

        // Ack in IDLE is ignored
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_ignored", 32'(wr_count), 32'd0);

        // Memory write acknowledged on the third edge
        send(2'b11, 8'h77, 8'h10);
        chk("mw_we_1", {mem_we, res_ready, mem_addr, mem_wdata}, {1'b1, 1'b0, 8'h10, 8'h77});
        @(negedge clk);
        chk("mw_we_2", {mem_we, res_ready, mem_addr, mem_wdata}, {1'b1, 1'b0, 8'h10, 8'h77});
        @(negedge clk);
        chk("mw_we_3", {mem_we, res_ready, mem_addr, mem_wdata}, {1'b1, 1'b0, 8'h10, 8'h77});
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("mw_done", {mem_we, res_ready, wr_count}, {1'b0, 1'b1, 8'd1});
        chk("mw_retain", {mem_addr, mem_wdata}, {8'h10, 8'h77});

        // Timeout with ack held low
        send(2'b11, 8'hAB, 8'h20);
        hi = 0;
        while (mem_we && hi < 100) begin
            hi = hi + 1;
            @(negedge clk);
        end
        chk("to_we_cycles", 32'(hi), 32'd15);
        chk("to_err", {err, wr_count, 7'd0, res_ready}, {1'b1, 8'd1, 7'd0, 1'b1});
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_err_clr", 32'(err), 32'd0);

        // Ack on the last permissible cycle wins over the timeout
        send(2'b11, 8'h01, 8'h30);
        ack_after(14);
        chk("last_ack", {err, mem_we, wr_count}, {1'b0, 1'b0, 8'd2});

        // Clear coinciding with timeout leaves err set
        send(2'b11, 8'h02, 8'h31);
        repeat (14) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_vs_timeout", {err, mem_we}, {1'b1, 1'b0});
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // 256 acknowledged writes interleaved with discards
        cnt0 = wr_count;
        for (int i = 0; i < 256; i++) begin
            send(2'b11, 8'(i), 8'(255 - i));
            ack_after(0);
            send(2'b10, 8'hEE, 8'hEE);
        end
        chk("wrap_count", 32'(wr_count), 32'(cnt0));
        chk("wrap_regs", {reg_a, reg_b}, 32'h5AC3);
        chk("wrap_last_mem", {mem_addr, mem_wdata}, {8'h00, 8'hFF});

        // Asynchronous reset during a write
        send(2'b11, 8'h99, 8'h44);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_we", 32'(mem_we), 32'd0);
        chk("rst_async_all", {reg_a, reg_b, mem_addr, mem_wdata}, 32'd0);
        chk("rst_async_cnt", {err, wr_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", 32'(res_ready), 32'd1);
        send(2'b00, 8'h3C, 8'h00);
        chk("post_rst_xfer", {reg_a, wr_count}, {8'h3C, 8'd0});

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
